// File: rtl/key_updown_counter_if.sv
// Bundle of the raw key inputs and the debounced counter outputs of
// key_updown_counter; the counter uses the slave view, the stimulus side the master view.
interface key_updown_counter_if;
  logic       KEY_UP;
  logic       KEY_DN;
  logic       KEY_CLR;
  logic [3:0] COUNT;
  logic       UP_PULSE;
  logic       DN_PULSE;
  logic       WRAP_FLAG;

  modport master (
    output KEY_UP, KEY_DN, KEY_CLR,
    input  COUNT, UP_PULSE, DN_PULSE, WRAP_FLAG
  );

  modport slave (
    input  KEY_UP, KEY_DN, KEY_CLR,
    output COUNT, UP_PULSE, DN_PULSE, WRAP_FLAG
  );
endinterface

// File: rtl/key_updown_counter.sv
// Push-button front end: per-key synchroniser, debounce filter and rising-edge
// strobe, feeding a 4-bit up/down counter that wraps or saturates at 0..MAX_VAL.
module key_updown_counter #(
  parameter int DEB_CYCLES = 4,
  parameter int MAX_VAL    = 15,
  parameter int WRAP       = 1
) (
  input logic                  CLK,
  input logic                  Reset,
  key_updown_counter_if.slave  bus
);

  localparam int             CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [3:0]     MAX      = 4'(MAX_VAL);

  localparam int K_UP  = 0;
  localparam int K_DN  = 1;
  localparam int K_CLR = 2;

  wire [2:0] raw;
  wire [2:0] rise;

  assign raw = {bus.KEY_CLR, bus.KEY_DN, bus.KEY_UP};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_key
      logic          ff1_reg;
      logic          ff2_reg;
      logic          stable_reg;
      logic          rise_reg;
      logic [CW-1:0] cnt_reg;

      // A level change is accepted only after ff2 has disagreed with the
      // debounced state for DEB_CYCLES consecutive cycles; any agreement restarts it.
      always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
          ff1_reg    <= 1'b0;
          ff2_reg    <= 1'b0;
          stable_reg <= 1'b0;
          rise_reg   <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          ff1_reg  <= raw[gi];
          ff2_reg  <= ff1_reg;
          rise_reg <= 1'b0;
          if (ff2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= ff2_reg;
            cnt_reg    <= '0;
            rise_reg   <= ff2_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign rise[gi] = rise_reg;
    end
  endgenerate

  logic [3:0] count_reg;
  logic [3:0] count_next;
  logic       wrap_reg;
  logic       wrap_next;

  // Clear beats everything; simultaneous up and down cancel out.
  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (rise[K_CLR]) begin
      count_next = 4'd0;
    end else if (rise[K_UP] && rise[K_DN]) begin
      count_next = count_reg;
    end else if (rise[K_UP]) begin
      if (count_reg < MAX) begin
        count_next = count_reg + 4'd1;
      end else if (WRAP != 0) begin
        count_next = 4'd0;
        wrap_next  = 1'b1;
      end
    end else if (rise[K_DN]) begin
      if (count_reg > 4'd0) begin
        count_next = count_reg - 4'd1;
      end else if (WRAP != 0) begin
        count_next = MAX;
        wrap_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      count_reg <= 4'd0;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign bus.COUNT     = count_reg;
  assign bus.UP_PULSE  = rise[K_UP];
  assign bus.DN_PULSE  = rise[K_DN];
  assign bus.WRAP_FLAG = wrap_reg;

endmodule

// File: tb/tb_key_updown_counter.sv
// Directed bench: three counters (15/wrap, 9/wrap, 9/saturate) share one set
// of key and reset stimuli; outputs are sampled on the falling clock edge.
module tb_key_updown_counter;

  logic clk = 1'b0;
  logic rst;
  logic key_up;
  logic key_dn;
  logic key_clr;

  always #5 clk = ~clk;

  key_updown_counter_if bus_a ();
  key_updown_counter_if bus_b ();
  key_updown_counter_if bus_c ();

  assign bus_a.KEY_UP  = key_up;
  assign bus_a.KEY_DN  = key_dn;
  assign bus_a.KEY_CLR = key_clr;
  assign bus_b.KEY_UP  = key_up;
  assign bus_b.KEY_DN  = key_dn;
  assign bus_b.KEY_CLR = key_clr;
  assign bus_c.KEY_UP  = key_up;
  assign bus_c.KEY_DN  = key_dn;
  assign bus_c.KEY_CLR = key_clr;

  key_updown_counter #(.DEB_CYCLES(4), .MAX_VAL(15), .WRAP(1)) u_dut_a (
    .CLK(clk), .Reset(rst), .bus(bus_a)
  );
  key_updown_counter #(.DEB_CYCLES(4), .MAX_VAL(9), .WRAP(1)) u_dut_b (
    .CLK(clk), .Reset(rst), .bus(bus_b)
  );
  key_updown_counter #(.DEB_CYCLES(4), .MAX_VAL(9), .WRAP(0)) u_dut_c (
    .CLK(clk), .Reset(rst), .bus(bus_c)
  );

  int errors = 0;
  int checks = 0;
  int up_a, dn_a, wrap_a, wrap_b, wrap_c, busy_cycles;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_tallies();
    up_a = 0; dn_a = 0; wrap_a = 0; wrap_b = 0; wrap_c = 0; busy_cycles = 0;
  endtask

  task automatic step();
    @(negedge clk);
    up_a   += int'(bus_a.UP_PULSE);
    dn_a   += int'(bus_a.DN_PULSE);
    wrap_a += int'(bus_a.WRAP_FLAG);
    wrap_b += int'(bus_b.WRAP_FLAG);
    wrap_c += int'(bus_c.WRAP_FLAG);
    if (bus_a.COUNT != 0 || bus_a.UP_PULSE || bus_a.DN_PULSE || bus_a.WRAP_FLAG ||
        bus_b.COUNT != 0 || bus_c.COUNT != 0)
      busy_cycles++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic press(input logic u, input logic d, input logic c);
    key_up = u; key_dn = d; key_clr = c;
    run(12);
    key_up = 1'b0; key_dn = 1'b0; key_clr = 1'b0;
    run(12);
  endtask

  logic [3:0] exp_a [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
  logic [3:0] exp_b [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
  logic [3:0] exp_c [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9};
  logic       bounce [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; key_up = 1'b0; key_dn = 1'b0; key_clr = 1'b0;
    clear_tallies();

    // Reset, then idle
    run(3);
    check("rst_count_a", 8'(bus_a.COUNT), 8'd0);
    check("rst_strobes_a", 8'({bus_a.UP_PULSE, bus_a.DN_PULSE, bus_a.WRAP_FLAG}), 8'd0);
    rst = 1'b0;
    clear_tallies();
    run(50);
    check("idle_busy_cycles", 8'(busy_cycles), 8'd0);

    // Single clean press: pulse after edge 5, count changes at edge 6
    clear_tallies();
    key_up = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 4) check("press_pulse_e4", 8'(bus_a.UP_PULSE), 8'd0);
      if (i == 5) begin
        check("press_pulse_e5", 8'(bus_a.UP_PULSE), 8'd1);
        check("press_count_e5", 8'(bus_a.COUNT), 8'd0);
      end
      if (i == 6) begin
        check("press_pulse_e6", 8'(bus_a.UP_PULSE), 8'd0);
        check("press_count_e6", 8'(bus_a.COUNT), 8'd1);
      end
    end
    check("press_one_pulse", 8'(up_a), 8'd1);
    key_up = 1'b0;
    run(20);
    check("release_count_a", 8'(bus_a.COUNT), 8'd1);
    check("release_no_pulse", 8'(up_a + dn_a), 8'd1);

    // Bounce: 2-cycle highs never qualify, the final held level does once
    clear_tallies();
    for (int i = 0; i < 8; i++) begin
      key_up = bounce[i];
      step();
    end
    check("bounce_rejected", 8'(up_a), 8'd0);
    key_up = 1'b1;
    run(20);
    key_up = 1'b0;
    run(20);
    check("bounce_one_pulse", 8'(up_a), 8'd1);
    check("bounce_count_a", 8'(bus_a.COUNT), 8'd2);
    check("bounce_count_c", 8'(bus_c.COUNT), 8'd2);

    // Ten up presses from zero: wrap on b, saturate on c
    press(1'b0, 1'b0, 1'b1);
    check("clr_count_a", 8'(bus_a.COUNT), 8'd0);
    clear_tallies();
    for (int i = 0; i < 10; i++) begin
      press(1'b1, 1'b0, 1'b0);
      check($sformatf("up%0d_count_a", i + 1), 8'(bus_a.COUNT), 8'(exp_a[i]));
      check($sformatf("up%0d_count_b", i + 1), 8'(bus_b.COUNT), 8'(exp_b[i]));
      check($sformatf("up%0d_count_c", i + 1), 8'(bus_c.COUNT), 8'(exp_c[i]));
    end
    check("up10_wraps_a", 8'(wrap_a), 8'd0);
    check("up10_wraps_b", 8'(wrap_b), 8'd1);
    check("up10_wraps_c", 8'(wrap_c), 8'd0);

    // One down press: b wraps 0 -> 9
    clear_tallies();
    press(1'b0, 1'b1, 1'b0);
    check("dn_count_a", 8'(bus_a.COUNT), 8'd9);
    check("dn_count_b", 8'(bus_b.COUNT), 8'd9);
    check("dn_count_c", 8'(bus_c.COUNT), 8'd8);
    check("dn_wraps_b", 8'(wrap_b), 8'd1);
    check("dn_wraps_a", 8'(wrap_a), 8'd0);

    // Saturation: c reaches 9, then stays there without a wrap flag
    press(1'b1, 1'b0, 1'b0);
    clear_tallies();
    press(1'b1, 1'b0, 1'b0);
    check("sat_count_c", 8'(bus_c.COUNT), 8'd9);
    check("sat_wraps_c", 8'(wrap_c), 8'd0);
    check("sat_count_b", 8'(bus_b.COUNT), 8'd1);
    check("sat_count_a", 8'(bus_a.COUNT), 8'd11);

    // Simultaneous up and down at 5
    press(1'b0, 1'b0, 1'b1);
    repeat (5) press(1'b1, 1'b0, 1'b0);
    check("five_count_a", 8'(bus_a.COUNT), 8'd5);
    clear_tallies();
    press(1'b1, 1'b1, 1'b0);
    check("both_up_pulses", 8'(up_a), 8'd1);
    check("both_dn_pulses", 8'(dn_a), 8'd1);
    check("both_count_a", 8'(bus_a.COUNT), 8'd5);
    check("both_count_b", 8'(bus_b.COUNT), 8'd5);

    // Clear beats up
    press(1'b1, 1'b0, 1'b1);
    check("clr_up_count_a", 8'(bus_a.COUNT), 8'd0);
    check("clr_up_count_b", 8'(bus_b.COUNT), 8'd0);

    // Asynchronous reset mid-press, then the held key re-qualifies
    repeat (7) press(1'b1, 1'b0, 1'b0);
    check("seven_count_a", 8'(bus_a.COUNT), 8'd7);
    key_dn = 1'b1;
    run(3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_count_a", 8'(bus_a.COUNT), 8'd0);
    check("async_rst_count_b", 8'(bus_b.COUNT), 8'd0);
    check("async_rst_strobes", 8'({bus_a.UP_PULSE, bus_a.DN_PULSE, bus_a.WRAP_FLAG}), 8'd0);
    run(2);
    rst = 1'b0;
    clear_tallies();
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 5) begin
        check("rearm_dn_pulse_e5", 8'(bus_a.DN_PULSE), 8'd1);
        check("rearm_count_e5", 8'(bus_a.COUNT), 8'd0);
      end
      if (i == 6) begin
        check("rearm_count_a", 8'(bus_a.COUNT), 8'd15);
        check("rearm_wrap_a", 8'(bus_a.WRAP_FLAG), 8'd1);
        check("rearm_count_b", 8'(bus_b.COUNT), 8'd9);
        check("rearm_count_c", 8'(bus_c.COUNT), 8'd0);
        check("rearm_wrap_c", 8'(bus_c.WRAP_FLAG), 8'd0);
      end
    end
    check("rearm_dn_pulses", 8'(dn_a), 8'd1);
    check("rearm_wraps_a", 8'(wrap_a), 8'd1);
    key_dn = 1'b0;
    run(20);
    check("final_count_a", 8'(bus_a.COUNT), 8'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_updown_counter.md
Name: key_updown_counter

Overview:
- Front-end input stage for the 7-segment display path.
- Takes three raw push-button inputs (up, down, clear) and passes each through a 2-FF synchroniser and a debounce filter, then a rising-edge detector.
- Maintains a 4-bit counter whose value drives the 4-bit binary input of the binary-to-BCD / 7-segment display block.
- Gives a clean, glitch-free, one-step-per-press value to display.

Parameters:
- DEB_CYCLES, 4, number of consecutive cycles a synchronised key level must differ from the debounced state before it is accepted (range 2..2^20; set large on board, small in simulation).
- MAX_VAL, 15, upper bound of COUNT (range 1..15); COUNT spans 0..MAX_VAL.
- WRAP, 1, 1 = wrap at the bounds, 0 = saturate at the bounds.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- KEY_UP  input  1  raw up button, active-high (1 = pressed), asynchronous to CLK, may bounce.
- KEY_DN  input  1  raw down button, same properties as KEY_UP.
- KEY_CLR  input  1  raw clear button, same properties as KEY_UP.
- COUNT  output  4  current count, registered; feeds the display converter input.
- UP_PULSE  output  1  one-cycle strobe, registered; a debounced up press was accepted.
- DN_PULSE  output  1  one-cycle strobe, registered; a debounced down press was accepted.
- WRAP_FLAG  output  1  one-cycle strobe, registered; COUNT wrapped (MAX_VAL->0 or 0->MAX_VAL).

Behaviour:
- Reset (async, Reset=1):
  - COUNT=0, UP_PULSE=0, DN_PULSE=0, WRAP_FLAG=0.
  - All synchroniser FFs, debounced states and debounce counters cleared (keys treated as released).
  - Deassertion takes effect at the next CLK edge.
  - Reset mid-press: the held key must be re-qualified from scratch and produces one fresh accepted press.
- Per-key path (three independent, identical instances):
  - ff1 <= raw; ff2 <= ff1.
  - If ff2 == stable: cnt <= 0.
  - Else if cnt == DEB_CYCLES-1: stable <= ff2, cnt <= 0, and rise <= ff2 for one cycle.
  - Else: cnt <= cnt+1.
  - Width of cnt = clog2(DEB_CYCLES).
- Latency:
  - Raw key goes high before edge 0 and is held.
  - stable rises at edge DEB_CYCLES+1; the rise strobe (UP_PULSE / DN_PULSE) is high for exactly the following cycle.
  - COUNT changes at edge DEB_CYCLES+2. With the default, COUNT changes at edge 6.
- Glitch rejection: any level that does not persist for DEB_CYCLES consecutive synchronised cycles is ignored, and the debounce counter restarts.
- Release: a debounced falling transition updates stable only. No pulse, no count change.
- Holding a key: exactly one step per press, no auto-repeat.
- Count update, evaluated on the cycle after the strobes, in priority order:
  1. clr strobe: COUNT <= 0, WRAP_FLAG=0.
  2. Up and down strobes in the same cycle: no change.
  3. Up strobe:
     - COUNT < MAX_VAL: COUNT+1.
     - COUNT == MAX_VAL: 0 with WRAP_FLAG=1 if WRAP=1; hold at MAX_VAL if WRAP=0.
  4. Down strobe:
     - COUNT > 0: COUNT-1.
     - COUNT == 0: MAX_VAL with WRAP_FLAG=1 if WRAP=1; hold at 0 if WRAP=0.
- WRAP_FLAG is high for exactly the one cycle following the wrapping update; it is 0 otherwise.
- COUNT never exceeds MAX_VAL.
- No combinational path from any input to any output.

Test Plan:
- Reset then idle: Reset=1 for 3 cycles, release, no keys pressed for 50 cycles -> COUNT=0 and all strobes 0 throughout.
- Single clean press, DEB_CYCLES=4: KEY_UP high from before edge 0, held 20 cycles -> UP_PULSE high exactly one cycle after edge 5, COUNT 0->1 at edge 6, release causes no further change.
- Bounce rejection: KEY_UP toggled 1,0,1,0 with 2-cycle high periods, then held high -> exactly one UP_PULSE, COUNT increments by exactly 1.
- Wrap vs saturate:
  - WRAP=1, MAX_VAL=9: 10 up presses from 0 -> COUNT goes 1..9 then 0, with WRAP_FLAG pulsed once on the 9->0 step; then one down press -> COUNT=9 with WRAP_FLAG pulsed.
  - WRAP=0: up press at 9 -> COUNT stays 9, WRAP_FLAG stays 0.
- Simultaneous and priority:
  - COUNT=5, KEY_UP and KEY_DN rise on the same cycle -> both strobes pulse, COUNT stays 5.
  - KEY_CLR rising together with KEY_UP -> COUNT=0.
- Reset mid-operation: COUNT=7 with KEY_DN held, assert Reset asynchronously mid-cycle -> outputs 0 immediately. After release with KEY_DN still held -> one DN_PULSE after DEB_CYCLES+2 cycles, COUNT=15 (MAX_VAL=15, WRAP=1) with WRAP_FLAG pulsed.
